// File: rtl/jtframe_sim_stimulus.sv
// Scripted cabinet-input player for simulation benches.
// Counts frames on LVBL falling edges and replays joystick/coin/start
// entries from a loadable script RAM once their frame stamp is reached.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   arm                   1 = run script, rising edge restarts it
//   LVBL                  vertical blank from the game, active low
//   load_we/addr/data     script RAM write port (accepted only while idle)
//   frame_cnt             frames since arm rose
//   joystick/coin/start   active-low cabinet inputs, player 1 in LSBs
//   busy, done            script running / script finished
module jtframe_sim_stimulus #(
    parameter int unsigned PLAYERS = 2,
    parameter int unsigned BUTTONS = 2,
    parameter int unsigned AW      = 8,
    parameter int unsigned FRAMEW  = 16,
    parameter int unsigned PULSE   = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  arm,
    input  logic                                  LVBL,
    input  logic                                  load_we,
    input  logic [AW-1:0]                         load_addr,
    input  logic [FRAMEW+PLAYERS*(BUTTONS+6)-1:0] load_data,
    output logic [FRAMEW-1:0]                     frame_cnt,
    output logic [PLAYERS*(BUTTONS+4)-1:0]        joystick,
    output logic [PLAYERS-1:0]                    coin,
    output logic [PLAYERS-1:0]                    start,
    output logic                                  busy,
    output logic                                  done
);
    localparam int unsigned JW = BUTTONS + 4;
    localparam int unsigned DW = FRAMEW + PLAYERS * (JW + 2);
    localparam int unsigned CW = (PULSE < 1) ? 1 : $clog2(PULSE + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_APPLY,
        ST_DONE
    } state_t;

    state_t                       r_state;
    logic [DW-1:0]                r_mem [0:(2**AW)-1];
    logic [DW-1:0]                r_rdata;
    logic [AW-1:0]                r_ptr;
    logic                         r_lvbl_l;
    logic                         r_arm_l;
    logic [PLAYERS-1:0][CW-1:0]   r_ccnt;
    logic [PLAYERS-1:0][CW-1:0]   r_scnt;

    logic                         w_frame_edge;
    logic                         w_arm_rise;
    logic [FRAMEW-1:0]            w_stamp;
    logic [PLAYERS*JW-1:0]        w_joy;
    logic [PLAYERS-1:0]           w_coin;
    logic [PLAYERS-1:0]           w_start;

    assign w_frame_edge = r_lvbl_l & ~LVBL;
    assign w_arm_rise   = arm & ~r_arm_l;
    assign w_stamp      = r_rdata[DW-1 -: FRAMEW];
    assign w_joy        = r_rdata[PLAYERS*JW-1:0];
    assign w_coin       = r_rdata[PLAYERS*JW +: PLAYERS];
    assign w_start      = r_rdata[PLAYERS*JW+PLAYERS +: PLAYERS];

    // Script RAM: writes only while idle, 1-clock read of the current pointer
    always_ff @(posedge clk) begin
        if (load_we && r_state == ST_IDLE) begin
            r_mem[load_addr] <= load_data;
        end
        r_rdata <= r_mem[r_ptr];
    end

    // Player FSM, frame counter and coin/start pulse timers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_lvbl_l  <= 1'b1;
            r_arm_l   <= 1'b0;
            r_ccnt    <= '0;
            r_scnt    <= '0;
            frame_cnt <= '0;
            joystick  <= '1;
            coin      <= '1;
            start     <= '1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_lvbl_l <= LVBL;
            r_arm_l  <= arm;
            if (!arm) begin
                r_state  <= ST_IDLE;
                r_ccnt   <= '0;
                r_scnt   <= '0;
                joystick <= '1;
                coin     <= '1;
                start    <= '1;
                busy     <= 1'b0;
                done     <= 1'b0;
            end else begin
                // Frame advance; pulse timers release their bit on reaching zero
                if (busy && w_frame_edge) begin
                    frame_cnt <= frame_cnt + FRAMEW'(1);
                    if (PULSE > 0) begin
                        for (int p = 0; p < PLAYERS; p++) begin
                            if (r_ccnt[p] != '0) begin
                                r_ccnt[p] <= r_ccnt[p] - CW'(1);
                                if (r_ccnt[p] == CW'(1)) coin[p] <= 1'b1;
                            end
                            if (r_scnt[p] != '0) begin
                                r_scnt[p] <= r_scnt[p] - CW'(1);
                                if (r_scnt[p] == CW'(1)) start[p] <= 1'b1;
                            end
                        end
                    end
                end
                case (r_state)
                    ST_IDLE: begin
                        if (w_arm_rise) begin
                            r_state   <= ST_FETCH;
                            r_ptr     <= '0;
                            frame_cnt <= '0;
                            busy      <= 1'b1;
                        end
                    end
                    ST_FETCH: r_state <= ST_WAIT;
                    ST_WAIT: begin
                        if (&w_stamp) begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (w_stamp <= frame_cnt) begin
                            r_state <= ST_APPLY;
                        end
                    end
                    ST_APPLY: begin
                        // Placed after the timer update so a load wins on the bits it sets
                        joystick <= ~w_joy;
                        for (int p = 0; p < PLAYERS; p++) begin
                            if (PULSE == 0) begin
                                coin[p]  <= ~w_coin[p];
                                start[p] <= ~w_start[p];
                            end else begin
                                if (w_coin[p]) begin
                                    coin[p]   <= 1'b0;
                                    r_ccnt[p] <= CW'(PULSE);
                                end
                                if (w_start[p]) begin
                                    start[p]  <= 1'b0;
                                    r_scnt[p] <= CW'(PULSE);
                                end
                            end
                        end
                        r_ptr <= r_ptr + AW'(1);
                        if (&r_ptr) begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_DONE: r_state <= ST_DONE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jtframe_sim_stimulus.sv
// Bench for jtframe_sim_stimulus: two instances (AW=8/PULSE=3 and AW=2/PULSE=0)
// driven by directed and random scripts, checked frame by frame against a
// per-frame behavioural model of the script player.
module tb_jtframe_sim_stimulus;
    typedef struct packed {
        logic [15:0] st;
        logic [1:0]  s;
        logic [1:0]  c;
        logic [11:0] j;
    } ent_t;

    logic        clk, rst_n, LVBL;
    logic        arm0, arm1, we0, we1;
    logic [7:0]  addr0;
    logic [1:0]  addr1;
    logic [31:0] data0, data1;
    logic [15:0] fc    [2];
    logic [11:0] joy   [2];
    logic [1:0]  coin  [2];
    logic [1:0]  start [2];
    logic        busy  [2];
    logic        done  [2];

    int n_cmp = 0;
    int n_mis = 0;

    ent_t scr0 [256];
    ent_t scr1 [4];
    ent_t e;

    int          m_frame [2];
    int          m_ptr   [2];
    bit          m_busy  [2];
    bit          m_done  [2];
    logic [11:0] m_joy   [2];
    logic [1:0]  m_coin  [2];
    logic [1:0]  m_start [2];
    int          m_ccnt  [2][2];
    int          m_scnt  [2][2];

    jtframe_sim_stimulus #(.PLAYERS(2), .BUTTONS(2), .AW(8), .FRAMEW(16), .PULSE(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .arm(arm0), .LVBL(LVBL),
        .load_we(we0), .load_addr(addr0), .load_data(data0),
        .frame_cnt(fc[0]), .joystick(joy[0]), .coin(coin[0]), .start(start[0]),
        .busy(busy[0]), .done(done[0])
    );

    jtframe_sim_stimulus #(.PLAYERS(2), .BUTTONS(2), .AW(2), .FRAMEW(16), .PULSE(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .arm(arm1), .LVBL(LVBL),
        .load_we(we1), .load_addr(addr1), .load_data(data1),
        .frame_cnt(fc[1]), .joystick(joy[1]), .coin(coin[1]), .start(start[1]),
        .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pulse_of(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 256 : 4;
    endfunction

    function automatic ent_t get_ent(input int k, input int i);
        return (k == 0) ? scr0[i] : scr1[i];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic m_reset(input int k);
        m_frame[k] = 0; m_ptr[k] = 0; m_busy[k] = 0; m_done[k] = 0;
        m_joy[k] = '0; m_coin[k] = '0; m_start[k] = '0;
        for (int b = 0; b < 2; b++) begin m_ccnt[k][b] = 0; m_scnt[k][b] = 0; end
    endtask

    // Apply every pending entry whose stamp has been reached
    task automatic m_apply(input int k);
        ent_t x;
        while (m_busy[k]) begin
            x = get_ent(k, m_ptr[k]);
            if (x.st == 16'hFFFF) begin
                m_busy[k] = 0; m_done[k] = 1;
            end else if (int'(x.st) > m_frame[k]) begin
                break;
            end else begin
                m_joy[k] = x.j;
                for (int b = 0; b < 2; b++) begin
                    if (pulse_of(k) == 0) begin
                        m_coin[k][b]  = x.c[b];
                        m_start[k][b] = x.s[b];
                    end else begin
                        if (x.c[b]) begin m_coin[k][b]  = 1'b1; m_ccnt[k][b] = pulse_of(k); end
                        if (x.s[b]) begin m_start[k][b] = 1'b1; m_scnt[k][b] = pulse_of(k); end
                    end
                end
                m_ptr[k]++;
                if (m_ptr[k] == depth_of(k)) begin m_busy[k] = 0; m_done[k] = 1; end
            end
        end
    endtask

    task automatic m_edge(input int k);
        if (!m_busy[k]) return;
        m_frame[k] = (m_frame[k] + 1) % 65536;
        for (int b = 0; b < 2; b++) begin
            if (m_ccnt[k][b] > 0) begin
                m_ccnt[k][b]--;
                if (m_ccnt[k][b] == 0) m_coin[k][b] = 1'b0;
            end
            if (m_scnt[k][b] > 0) begin
                m_scnt[k][b]--;
                if (m_scnt[k][b] == 0) m_start[k][b] = 1'b0;
            end
        end
        m_apply(k);
    endtask

    task automatic m_arm(input int k);
        m_reset(k);
        m_busy[k] = 1;
        m_apply(k);
    endtask

    task automatic m_disarm(input int k);
        int f;
        f = m_frame[k];
        m_reset(k);
        m_frame[k] = f;
    endtask

    // ---------------- checks and stimulus helpers ----------------
    task automatic chk_inst(input int k);
        string       t;
        logic [11:0] ej;
        logic [1:0]  ec, es;
        t  = $sformatf("i%0d@f%0d", k, m_frame[k]);
        ej = ~m_joy[k];
        ec = ~m_coin[k];
        es = ~m_start[k];
        chk({t, " frame_cnt"}, 32'(fc[k]), 32'(m_frame[k]));
        chk({t, " joystick"}, 32'(joy[k]), 32'(ej));
        chk({t, " coin"}, 32'(coin[k]), 32'(ec));
        chk({t, " start"}, 32'(start[k]), 32'(es));
        chk({t, " busy"}, 32'(busy[k]), 32'(m_busy[k]));
        chk({t, " done"}, 32'(done[k]), 32'(m_done[k]));
    endtask

    task automatic frame();
        LVBL = 1'b0;
        m_edge(0);
        m_edge(1);
        tick(50);
        chk_inst(0);
        chk_inst(1);
        tick(50);
        LVBL = 1'b1;
        tick(100);
    endtask

    task automatic load(input int k, input int a, input ent_t x);
        if (k == 0) begin we0 = 1'b1; addr0 = 8'(a); data0 = x; end
        else        begin we1 = 1'b1; addr1 = 2'(a); data1 = x; end
        tick(1);
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    task automatic put(input int k, input int a, input ent_t x);
        if (k == 0) scr0[a] = x; else scr1[a] = x;
        load(k, a, x);
    endtask

    task automatic mk(input int st, input int s, input int c, input int j);
        e.st = 16'(st); e.s = 2'(s); e.c = 2'(c); e.j = 12'(j);
    endtask

    task automatic arm_on(input int k);
        if (k == 0) arm0 = 1'b1; else arm1 = 1'b1;
        m_arm(k);
        tick(40);
        chk_inst(k);
    endtask

    task automatic arm_off(input int k);
        if (k == 0) arm0 = 1'b0; else arm1 = 1'b0;
        m_disarm(k);
        tick(1);
        chk_inst(k);
    endtask

    int st, run, r;

    initial begin
        rst_n = 1'b0; LVBL = 1'b1;
        arm0 = 1'b0; arm1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        m_reset(0);
        m_reset(1);
        #22;
        chk_inst(0);
        chk_inst(1);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Directed script: coin pulse with re-trigger, joystick level, same-stamp pair
        mk(2, 0, 1, 0);          put(0, 0, e);
        mk(3, 0, 1, 0);          put(0, 1, e);
        mk(5, 0, 0, 12'h001);    put(0, 2, e);
        mk(9, 0, 0, 0);          put(0, 3, e);
        mk(12, 2, 0, 12'h040);   put(0, 4, e);
        mk(14, 1, 2, 12'h3C5);   put(0, 5, e);
        mk(14, 0, 0, 12'h00A);   put(0, 6, e);
        mk(16'hFFFF, 0, 0, 0);   put(0, 7, e);
        tick(2);
        arm_on(0);
        for (int f = 1; f <= 18; f++) begin
            frame();
            if (f == 5) chk("joy1 up at frame 5", 32'(joy[0][0]), 32'd0);
            if (f == 5) chk("coin1 held at frame 5", 32'(coin[0][0]), 32'd0);
            if (f == 6) chk("coin1 released at frame 6", 32'(coin[0][0]), 32'd1);
            if (f == 9) chk("joy idle at frame 9", 32'(joy[0]), 32'hFFF);
            if (f == 17) chk("frame frozen at 14", 32'(fc[0]), 32'd14);
        end

        // Writes while done are dropped; replay must match the original script
        mk(1, 3, 3, 12'hFFF);
        load(0, 0, e);
        load(0, 2, e);
        arm_off(0);
        arm_on(0);
        for (int f = 1; f <= 3; f++) frame();
        arm_off(0);
        arm_on(0);
        for (int f = 1; f <= 16; f++) frame();

        // Random script with same-stamp runs and late (catch-up) entries
        arm_off(0);
        st = 0;
        run = 0;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0 && st >= 2) begin
                st -= 2; run = 0;
            end else if (r < 4 && run < 6) begin
                run++;
            end else begin
                st += $urandom_range(1, 3); run = 0;
            end
            mk(st, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            put(0, i, e);
        end
        mk(16'hFFFF, 0, 0, 0);
        put(0, 24, e);
        arm_on(0);
        for (int f = 0; f < 150 && !m_done[0]; f++) frame();
        frame();
        frame();
        arm_off(0);

        // Small RAM: four real entries, done on pointer wrap; level coin/start
        mk(1, 1, 2, $urandom);                                        put(1, 0, e);
        mk(2, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);  put(1, 1, e);
        mk(2, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);  put(1, 2, e);
        mk(4, 2, 1, $urandom);                                        put(1, 3, e);
        arm_on(1);
        for (int f = 1; f <= 6; f++) frame();
        chk("wrap done", 32'(done[1]), 32'd1);
        chk("wrap frame frozen", 32'(fc[1]), 32'd4);

        // Asynchronous reset while the small instance waits on a far stamp
        arm_off(1);
        mk(1, 2, 1, 12'h155);    put(1, 0, e);
        mk(50, 0, 0, 0);         put(1, 1, e);
        arm_on(1);
        frame();
        frame();
        chk("pre-reset joystick active", 32'(joy[1]), 32'hEAA);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_reset(0);
        m_reset(1);
        #1;
        chk_inst(0);
        chk_inst(1);
        arm0 = 1'b0;
        arm1 = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk_inst(0);
        chk_inst(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
